// File: rtl/pc_branch_sequencer_if.sv
// Bus between the branch-compare unit / fetch consumer and pc_branch_sequencer.
// Build option: BRANCH_STATS_EN adds the taken_count / stall_count statistics.
//   stall, br_valid, br_taken, br_target : driven by the master (pipeline side)
//   pc, pc_valid, flush, halted          : driven by the slave (sequencer)
//   taken_count, stall_count             : slave-driven statistics (BRANCH_STATS_EN only)
interface pc_branch_sequencer_if #(
    parameter int unsigned PC_W = 8
);
    logic            stall;
    logic            br_valid;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] pc;
    logic            pc_valid;
    logic            flush;
    logic            halted;
`ifdef BRANCH_STATS_EN
    logic [7:0]      taken_count;
    logic [7:0]      stall_count;

    modport master (
        output stall, br_valid, br_taken, br_target,
        input  pc, pc_valid, flush, halted, taken_count, stall_count
    );
    modport slave (
        input  stall, br_valid, br_taken, br_target,
        output pc, pc_valid, flush, halted, taken_count, stall_count
    );
`else
    modport master (
        output stall, br_valid, br_taken, br_target,
        input  pc, pc_valid, flush, halted
    );
    modport slave (
        input  stall, br_valid, br_taken, br_target,
        output pc, pc_valid, flush, halted
    );
`endif
endinterface

// File: rtl/pc_branch_sequencer.sv
// Program counter sequencer: steps fetch addresses, redirects on taken
// branches with a fixed flush window, honours stalls, halts at the exit label.
// Build option: BRANCH_STATS_EN adds saturating taken/stall counters.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : pc_branch_sequencer_if.slave (stall, br_valid, br_taken, br_target in;
//         pc, pc_valid, flush, halted [, taken_count, stall_count] out, all registered)
module pc_branch_sequencer #(
    parameter int unsigned PC_W         = 8,
    parameter int unsigned PC_STEP      = 4,
    parameter int unsigned RESET_PC     = 4,
    parameter int unsigned HALT_PC      = 128,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_branch_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        FLUSH,
        HALT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] pc_inc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic            take;
    logic            pc_valid_q;
    logic            flush_q;
    logic            halted_q;

    // Next-state / next-pc decode.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        cnt_nxt   = cnt;
        pc_inc    = pc_q + PC_W'(PC_STEP);
        take      = bus.br_valid && bus.br_taken;
        case (state)
            BOOT: state_nxt = FETCH;
            FETCH: begin
                // A taken branch wins over a stall in the same cycle.
                if (take) begin
                    pc_nxt    = bus.br_target;
                    cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
                    state_nxt = FLUSH;
                end else if (!bus.stall) begin
                    pc_nxt = pc_inc;
                    if (pc_inc == PC_W'(HALT_PC)) begin
                        state_nxt = HALT;
                    end
                end
            end
            FLUSH: begin
                if (cnt == CNT_W'(0)) begin
                    state_nxt = (pc_q == PC_W'(HALT_PC)) ? HALT : FETCH;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HALT: state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase
    end

    // State, pc and registered status decode (outputs follow the next state).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc_q       <= PC_W'(RESET_PC);
            cnt        <= '0;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc_q       <= pc_nxt;
            cnt        <= cnt_nxt;
            pc_valid_q <= (state_nxt == FETCH);
            flush_q    <= (state_nxt == FLUSH);
            halted_q   <= (state_nxt == HALT);
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_valid = pc_valid_q;
    assign bus.flush    = flush_q;
    assign bus.halted   = halted_q;

`ifdef BRANCH_STATS_EN
    logic [7:0] taken_q;
    logic [7:0] stall_q;

    // Saturating statistics, only FETCH cycles count; a stalled cycle that
    // also takes a branch is a branch, not a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_q <= '0;
            stall_q <= '0;
        end else if (state == FETCH) begin
            if (take && taken_q != 8'hFF) begin
                taken_q <= taken_q + 8'd1;
            end
            if (!take && bus.stall && stall_q != 8'hFF) begin
                stall_q <= stall_q + 8'd1;
            end
        end
    end

    assign bus.taken_count = taken_q;
    assign bus.stall_count = stall_q;
`endif
endmodule
